// File: rtl/conv_pkg.sv
// conv_pkg: state encoding, status codes and outstanding-window limit
// shared by conv_layer_seq and its helpers.
package conv_pkg;

  localparam logic [3:0] STATUS_IDLE  = 4'd0;
  localparam logic [3:0] STATUS_CALC  = 4'd1;
  localparam logic [3:0] STATUS_RUN   = 4'd2;
  localparam logic [3:0] STATUS_DRAIN = 4'd3;
  localparam logic [3:0] STATUS_DONE  = 4'd4;
  localparam logic [3:0] STATUS_ERR   = 4'd8;

  // State values double as the externally visible status code.
  typedef enum logic [3:0] {
    ST_IDLE  = STATUS_IDLE,
    ST_CALC  = STATUS_CALC,
    ST_RUN   = STATUS_RUN,
    ST_DRAIN = STATUS_DRAIN,
    ST_DONE  = STATUS_DONE,
    ST_ERR   = STATUS_ERR
  } state_t;

  // Maximum number of windows in flight before issue is throttled.
  localparam logic [3:0] OUTSTANDING_MAX = 4'd15;

endpackage

// File: rtl/conv_dim_div.sv
// conv_dim_div: iterative unsigned divider, one subtraction per cycle.
// quotient = numerator / divisor; done stays high until the next start.
// A zero divisor finishes immediately with quotient 0.
module conv_dim_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:0] numerator,
  input  logic [7:0]  divisor,
  output logic [16:0] quotient,
  output logic        done
);

  logic        busy;
  logic [16:0] rem;
  logic [16:0] div_ext;

  assign div_ext = {9'd0, divisor};

  // Repeated subtraction until the remainder drops below the divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      quotient <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      done     <= 1'b0;
      rem      <= numerator;
      quotient <= '0;
    end else if (busy) begin
      if ((div_ext != '0) && (rem >= div_ext)) begin
        rem      <= rem - div_ext;
        quotient <= quotient + 17'd1;
      end else begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_seq.sv
// conv_layer_seq: convolution layer window sequencer.
// Latches layer geometry on start, computes output dimensions with two
// iterative dividers, then issues one window request per (f, c, oy, ox)
// with at most 15 windows outstanding, drains results and reports done.
// Optional feature macro: CONV_SEQ_PERF_EN adds perf_cycles/perf_stalls.
module conv_layer_seq
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_data_wid,
  input  logic [15:0] cfg_data_hei,
  input  logic [15:0] cfg_data_ch,
  input  logic [15:0] cfg_filter_wid,
  input  logic [15:0] cfg_filter_hei,
  input  logic [15:0] cfg_filter_num,
  input  logic [7:0]  cfg_stride_h,
  input  logic [7:0]  cfg_stride_v,
  input  logic [3:0]  cfg_pad_h,
  input  logic [3:0]  cfg_pad_v,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [16:0] win_row,
  output logic [16:0] win_col,
  output logic [15:0] win_ch,
  output logic [15:0] win_filt,
  output logic        win_first_ch,
  output logic        win_last_ch,
  input  logic        res_valid,
  output logic [15:0] out_wid,
  output logic [15:0] out_hei,
  output logic [3:0]  status,
  output logic [15:0] cin_cnt,
  output logic [15:0] cout_cnt
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls
`endif
);

  state_t      state;
  logic [15:0] data_wid, data_hei, data_ch;
  logic [15:0] filt_wid, filt_hei, filt_num;
  logic [7:0]  stride_h, stride_v;
  logic [3:0]  pad_h, pad_v;
  logic        calc_launched;
  logic [15:0] f_idx, c_idx, oy_idx, ox_idx;
  logic [3:0]  outstanding;

  logic [16:0] span_h, span_v, numer_h, numer_v;
  logic [16:0] col_init, row_init;
  logic [16:0] quot_h, quot_v;
  logic        cfg_err, div_start, div_h_done, div_v_done;
  logic        start_ok, accept, retire, in_run;
  logic        last_ox, last_oy, last_c, last_f;

  // Padded extents, divider numerators, window origins and config checks.
  always_comb begin
    span_h   = {1'b0, data_wid} + {12'd0, pad_h, 1'b0};
    span_v   = {1'b0, data_hei} + {12'd0, pad_v, 1'b0};
    numer_h  = span_h - {1'b0, filt_wid};
    numer_v  = span_v - {1'b0, filt_hei};
    col_init = 17'd0 - {13'd0, pad_h};
    row_init = 17'd0 - {13'd0, pad_v};
    cfg_err  = (stride_h == '0) || (stride_v == '0) ||
               (data_ch == '0) || (filt_num == '0) ||
               (filt_wid == '0) || (filt_hei == '0) ||
               ({1'b0, filt_wid} > span_h) || ({1'b0, filt_hei} > span_v);
  end

  assign in_run    = (state == ST_RUN);
  assign win_valid = in_run && (outstanding != OUTSTANDING_MAX);
  assign accept    = win_valid && win_ready;
  assign retire    = res_valid && (outstanding != '0);
  assign start_ok  = start && !abort &&
                     ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign div_start = (state == ST_CALC) && !calc_launched && !cfg_err;

  assign last_ox = (ox_idx == out_wid - 16'd1);
  assign last_oy = (oy_idx == out_hei - 16'd1);
  assign last_c  = (c_idx == data_ch - 16'd1);
  assign last_f  = (f_idx == filt_num - 16'd1);

  assign win_ch       = c_idx;
  assign win_filt     = f_idx;
  assign win_first_ch = in_run && (c_idx == '0);
  assign win_last_ch  = in_run && last_c;
  assign cin_cnt      = c_idx;
  assign cout_cnt     = f_idx;
  assign status       = state;

  conv_dim_div u_div_h (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .numerator (numer_h),
    .divisor   (stride_h),
    .quotient  (quot_h),
    .done      (div_h_done)
  );

  conv_dim_div u_div_v (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .numerator (numer_v),
    .divisor   (stride_v),
    .quotient  (quot_v),
    .done      (div_v_done)
  );

  // Layer sequencing FSM: config latch, dimension calc, window loops, drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      calc_launched <= 1'b0;
      data_wid      <= '0;
      data_hei      <= '0;
      data_ch       <= '0;
      filt_wid      <= '0;
      filt_hei      <= '0;
      filt_num      <= '0;
      stride_h      <= '0;
      stride_v      <= '0;
      pad_h         <= '0;
      pad_v         <= '0;
      f_idx         <= '0;
      c_idx         <= '0;
      oy_idx        <= '0;
      ox_idx        <= '0;
      win_row       <= '0;
      win_col       <= '0;
      outstanding   <= '0;
      out_wid       <= '0;
      out_hei       <= '0;
    end else if (abort) begin
      state         <= ST_IDLE;
      calc_launched <= 1'b0;
      f_idx         <= '0;
      c_idx         <= '0;
      oy_idx        <= '0;
      ox_idx        <= '0;
      win_row       <= '0;
      win_col       <= '0;
      outstanding   <= '0;
    end else begin
      if (accept && !retire) begin
        outstanding <= outstanding + 4'd1;
      end else if (!accept && retire) begin
        outstanding <= outstanding - 4'd1;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            data_wid      <= cfg_data_wid;
            data_hei      <= cfg_data_hei;
            data_ch       <= cfg_data_ch;
            filt_wid      <= cfg_filter_wid;
            filt_hei      <= cfg_filter_hei;
            filt_num      <= cfg_filter_num;
            stride_h      <= cfg_stride_h;
            stride_v      <= cfg_stride_v;
            pad_h         <= cfg_pad_h;
            pad_v         <= cfg_pad_v;
            calc_launched <= 1'b0;
            f_idx         <= '0;
            c_idx         <= '0;
            oy_idx        <= '0;
            ox_idx        <= '0;
            win_row       <= '0;
            win_col       <= '0;
            state         <= ST_CALC;
          end
        end
        ST_CALC: begin
          // First CALC cycle validates the latched config and launches the
          // dividers; later cycles wait for both axes to finish.
          if (!calc_launched) begin
            if (cfg_err) begin
              state <= ST_ERR;
            end else begin
              calc_launched <= 1'b1;
            end
          end else if (div_h_done && div_v_done) begin
            out_wid <= 16'(quot_h + 17'd1);
            out_hei <= 16'(quot_v + 17'd1);
            win_col <= col_init;
            win_row <= row_init;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Window origins advance by stride instead of multiplying indices.
          if (accept) begin
            if (!last_ox) begin
              ox_idx  <= ox_idx + 16'd1;
              win_col <= win_col + {9'd0, stride_h};
            end else begin
              ox_idx  <= '0;
              win_col <= col_init;
              if (!last_oy) begin
                oy_idx  <= oy_idx + 16'd1;
                win_row <= win_row + {9'd0, stride_v};
              end else begin
                oy_idx  <= '0;
                win_row <= row_init;
                if (!last_c) begin
                  c_idx <= c_idx + 16'd1;
                end else begin
                  c_idx <= '0;
                  f_idx <= f_idx + 16'd1;
                  if (last_f) begin
                    state <= ST_DRAIN;
                  end
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  // Saturating activity counters: busy cycles and back-pressure stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (((state == ST_CALC) || (state == ST_RUN) || (state == ST_DRAIN)) &&
          (perf_cycles != '1)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (win_valid && !win_ready && (perf_stalls != '1)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`else
  // start_ok only feeds the optional counters.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// tb_conv_layer_seq: randomized self-checking bench for conv_layer_seq.
// Expected windows come from plain nested loops over the layer geometry.
module tb_conv_layer_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] cfg_data_wid, cfg_data_hei, cfg_data_ch;
  logic [15:0] cfg_filter_wid, cfg_filter_hei, cfg_filter_num;
  logic [7:0]  cfg_stride_h, cfg_stride_v;
  logic [3:0]  cfg_pad_h, cfg_pad_v;
  logic        win_valid, win_ready;
  logic [16:0] win_row, win_col;
  logic [15:0] win_ch, win_filt;
  logic        win_first_ch, win_last_ch;
  logic        res_valid;
  logic [15:0] out_wid, out_hei;
  logic [3:0]  status;
  logic [15:0] cin_cnt, cout_cnt;

  always #5 clk = ~clk;

  conv_layer_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_data_wid   (cfg_data_wid),
    .cfg_data_hei   (cfg_data_hei),
    .cfg_data_ch    (cfg_data_ch),
    .cfg_filter_wid (cfg_filter_wid),
    .cfg_filter_hei (cfg_filter_hei),
    .cfg_filter_num (cfg_filter_num),
    .cfg_stride_h   (cfg_stride_h),
    .cfg_stride_v   (cfg_stride_v),
    .cfg_pad_h      (cfg_pad_h),
    .cfg_pad_v      (cfg_pad_v),
    .win_valid      (win_valid),
    .win_ready      (win_ready),
    .win_row        (win_row),
    .win_col        (win_col),
    .win_ch         (win_ch),
    .win_filt       (win_filt),
    .win_first_ch   (win_first_ch),
    .win_last_ch    (win_last_ch),
    .res_valid      (res_valid),
    .out_wid        (out_wid),
    .out_hei        (out_hei),
    .status         (status),
    .cin_cnt        (cin_cnt),
    .cout_cnt       (cout_cnt)
  );

  typedef struct {
    int dw, dh, ch, fw, fh, fn, sh, sv, ph, pv;
  } cfg_t;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [127:0] exp_q[$];
  int           m_ow = 0;
  int           m_oh = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_tuple(input int row, input int col, input int c,
                                            input int f, input int nch);
    logic [16:0] r, cl;
    logic [15:0] cc, ff;
    r  = 17'(row);
    cl = 17'(col);
    cc = 16'(c);
    ff = 16'(f);
    return {28'd0, r, cl, cc, ff, (c == 0), (c == nch - 1), cc, ff};
  endfunction

  function automatic logic [127:0] obs_tuple();
    return {28'd0, win_row, win_col, win_ch, win_filt, win_first_ch, win_last_ch,
            cin_cnt, cout_cnt};
  endfunction

  // Launch one layer and play it out; stop_at>0 returns mid-RUN at that cycle.
  task automatic run_layer(input cfg_t c, input int rdy_pct, input int res_mode,
                           input int hold, input int stop_at);
    bit           err, a, r, stall_prev;
    int           ow, oh, acc, m_out;
    logic [127:0] cur, held;
    int           due[$];

    err = (c.sh == 0) || (c.sv == 0) || (c.ch == 0) || (c.fn == 0) ||
          (c.fw == 0) || (c.fh == 0) ||
          (c.fw > c.dw + 2 * c.ph) || (c.fh > c.dh + 2 * c.pv);
    exp_q.delete();
    ow = 0;
    oh = 0;
    if (!err) begin
      ow = (c.dw + 2 * c.ph - c.fw) / c.sh + 1;
      oh = (c.dh + 2 * c.pv - c.fh) / c.sv + 1;
      for (int f = 0; f < c.fn; f++)
        for (int ch = 0; ch < c.ch; ch++)
          for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
              exp_q.push_back(mk_tuple(oy * c.sv - c.pv, ox * c.sh - c.ph, ch, f, c.ch));
    end

    win_ready      = 1'b0;
    res_valid      = 1'b0;
    cfg_data_wid   = 16'(c.dw);
    cfg_data_hei   = 16'(c.dh);
    cfg_data_ch    = 16'(c.ch);
    cfg_filter_wid = 16'(c.fw);
    cfg_filter_hei = 16'(c.fh);
    cfg_filter_num = 16'(c.fn);
    cfg_stride_h   = 8'(c.sh);
    cfg_stride_v   = 8'(c.sv);
    cfg_pad_h      = 4'(c.ph);
    cfg_pad_v      = 4'(c.pv);
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (status != 4'd1) break;
    end
    check("calc_status", status, err ? 4'd8 : 4'd2);
    if (err) begin
      repeat (3) @(negedge clk);
      check("err_idle", {status, win_valid}, {4'd8, 1'b0});
      check("err_dims", {out_wid, out_hei}, {16'(m_ow), 16'(m_oh)});
      @(posedge clk); #1;
      return;
    end
    m_ow = ow;
    m_oh = oh;
    check("out_dims", {out_wid, out_hei}, {16'(ow), 16'(oh)});
    @(posedge clk); #1;

    m_out      = 0;
    acc        = 0;
    stall_prev = 1'b0;
    held       = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (stop_at > 0 && cyc == stop_at) return;
      win_ready = ($urandom_range(99) < rdy_pct);
      if (res_mode == 0) begin
        res_valid = (due.size() > 0) && (due[0] == cyc);
        if (res_valid) void'(due.pop_front());
      end else begin
        res_valid = (cyc >= hold) && ($urandom_range(1) == 1);
      end
      @(negedge clk);
      cur = obs_tuple();
      if (hold > 0 && cyc == hold - 1) begin
        check("hold_accepted", acc, 15);
        check("hold_valid", win_valid, 1'b0);
      end
      if (status == 4'd2 && m_out == 15) check("full_block", win_valid, 1'b0);
      if (stall_prev && win_valid) check("stall_hold", cur, held);
      a = win_valid && win_ready;
      if (a) begin
        if (exp_q.size() == 0) check("extra_win", cur, '1);
        else check("win", cur, exp_q.pop_front());
        acc++;
        if (res_mode == 0) due.push_back(cyc + 3);
      end
      r = res_valid && (m_out != 0);
      if (a && !r) m_out++;
      else if (!a && r) m_out--;
      stall_prev = win_valid && !win_ready;
      held       = cur;
      if (status == 4'd4) break;
      @(posedge clk); #1;
    end
    check("done_status", status, 4'd4);
    check("done_cout", cout_cnt, 16'(c.fn));
    check("windows_left", exp_q.size(), 0);
    check("done_valid", win_valid, 1'b0);
    @(posedge clk); #1;
    win_ready = 1'b0;
    res_valid = 1'b0;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.dw = $urandom_range(1, 9);
    c.dh = $urandom_range(1, 9);
    c.ch = $urandom_range(1, 3);
    c.fw = $urandom_range(1, 4);
    c.fh = $urandom_range(1, 4);
    c.fn = $urandom_range(1, 3);
    c.sh = $urandom_range(0, 3);
    c.sv = $urandom_range(1, 3);
    c.ph = $urandom_range(0, 2);
    c.pv = $urandom_range(0, 2);
    return c;
  endfunction

  initial begin
    cfg_t c;
    rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
    cfg_data_wid = '0; cfg_data_hei = '0; cfg_data_ch = '0;
    cfg_filter_wid = '0; cfg_filter_hei = '0; cfg_filter_num = '0;
    cfg_stride_h = '0; cfg_stride_v = '0; cfg_pad_h = '0; cfg_pad_v = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_win", {win_valid, win_row, win_col, win_ch, win_filt, win_first_ch, win_last_ch}, '0);
    check("rst_misc", {out_wid, out_hei, status, cin_cnt, cout_cnt}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    c = '{8, 8, 2, 3, 3, 1, 1, 1, 0, 0};
    run_layer(c, 100, 0, 0, 0);
    c = '{5, 5, 1, 3, 3, 2, 2, 2, 1, 1};
    run_layer(c, 60, 1, 0, 0);
    c = '{6, 6, 1, 3, 3, 1, 0, 1, 0, 0};
    run_layer(c, 100, 1, 0, 0);
    c = '{5, 5, 2, 3, 3, 2, 2, 2, 1, 1};
    run_layer(c, 70, 0, 0, 0);
    c = '{6, 6, 2, 3, 3, 1, 1, 1, 0, 0};
    run_layer(c, 100, 1, 40, 0);
    for (int i = 0; i < 8; i++) begin
      c = rand_cfg();
      run_layer(c, $urandom_range(30, 100), $urandom_range(1), 0, 0);
    end

    // abort mid-RUN with a simultaneous start
    c = '{3, 3, 4, 3, 3, 4, 1, 1, 0, 0};
    run_layer(c, 100, 1, 0, 6);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    check("abort_clear", {status, win_valid, cin_cnt, cout_cnt}, {4'd0, 1'b0, 16'd0, 16'd0});
    repeat (4) @(negedge clk);
    check("abort_start_ignored", status, 4'd0);
    @(posedge clk); #1;

    // reset mid-RUN
    c = '{6, 6, 2, 3, 3, 2, 1, 1, 1, 1};
    run_layer(c, 100, 1, 0, 10);
    rst = 1'b1; win_ready = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    check("rst_mid", {status, win_valid, cin_cnt, cout_cnt, out_wid, out_hei}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ow = 0;
    m_oh = 0;
    repeat (3) @(negedge clk);
    check("rst_release", {status, win_valid}, {4'd0, 1'b0});
    @(posedge clk); #1;
    c = rand_cfg();
    run_layer(c, 80, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_layer_seq.md
CONV_LAYER_SEQ -- requirements
Module: conv_layer_seq

Interface
REQ-001 SHALL have the following ports, clock and reset first; reset rst is asynchronous and active-high, and the clock is clk.
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle layer launch pulse
- abort  in  1  one-cycle cancel pulse
- cfg_data_wid, cfg_data_hei, cfg_data_ch, cfg_filter_wid, cfg_filter_hei, cfg_filter_num  in  16 each  layer geometry
- cfg_stride_h, cfg_stride_v  in  8 each  stride
- cfg_pad_h, cfg_pad_v  in  4 each  zero padding
- win_valid  out  1  window request valid
- win_ready  in  1  datapath accepts window
- win_row, win_col  out  17 each  signed top-left input coordinate: oy*stride_v - pad_v and ox*stride_h - pad_h
- win_ch, win_filt  out  16 each  channel and filter index
- win_first_ch, win_last_ch  out  1 each  c==0 and c==data_ch-1
- res_valid  in  1  one window result retired
- out_wid, out_hei  out  16 each  computed output dimensions
- status  out  4  phase code
- cin_cnt  out  16  current channel index
- cout_cnt  out  16  filters completed

Function
REQ-002 SHALL implement FSM states IDLE (status 0), CALC (1), RUN (2), DRAIN (3), DONE (4) and ERR (8).
REQ-003 In IDLE, DONE or ERR, start SHALL latch all cfg_* inputs and enter CALC on the next edge; start SHALL be ignored in every other state.
REQ-004 CALC SHALL compute out = (data + 2*pad - filter)/stride + 1 per axis by iterative subtraction, one subtract per cycle per axis, both axes in parallel, in at least 17-bit arithmetic.
REQ-005 CALC SHALL enter ERR instead of RUN when any of the following holds: a stride is 0; filter > data + 2*pad; any of data_ch, filter_num or a filter dimension is 0.
REQ-006 RUN SHALL iterate the loops f (outer), c, oy, ox (inner) and advance the innermost index only on the cycle where win_valid && win_ready.
REQ-007 While win_valid=1 and win_ready=0, all win_* outputs SHALL hold stable.
REQ-008 An outstanding counter (4-bit) SHALL increment on each accepted window and decrement on each res_valid; both in the same cycle SHALL leave it unchanged.
REQ-009 win_valid SHALL be deasserted while outstanding==15.
REQ-010 After the last window is accepted, the FSM SHALL enter DRAIN, and SHALL enter DONE once outstanding==0.
REQ-011 res_valid with outstanding==0 SHALL be ignored, with no underflow.
REQ-012 cout_cnt SHALL increment when f advances; in DONE, cout_cnt SHALL equal filter_num.
REQ-013 cin_cnt SHALL track c.
REQ-014 abort in any state SHALL return the FSM to IDLE on the next edge, clearing counters, outstanding and win_valid; abort together with start SHALL give priority to abort.
REQ-015 out_wid and out_hei SHALL hold their last computed values until the next CALC completes.

Reset
REQ-016 On rst, the FSM SHALL be IDLE and every output and counter SHALL be 0.
REQ-017 rst asserted mid-RUN SHALL discard the layer, with no pending win_valid after release.

Configuration
REQ-018 With CONV_SEQ_PERF_EN defined, the block SHALL add outputs perf_cycles (32) and perf_stalls (32):
- perf_cycles counts cycles in CALC, RUN and DRAIN;
- perf_stalls counts cycles with win_valid && !win_ready;
- both clear on start, saturate at all-ones, and clear on reset.
Without CONV_SEQ_PERF_EN, neither port nor its logic SHALL exist.

Structure
REQ-019 The state enum, the status codes and the outstanding depth constant (15) SHALL live in package conv_pkg.
REQ-020 The iterative divider SHALL be sub-module conv_dim_div (inputs numerator and divisor, handshake start/done), instantiated once per axis.

Verification
REQ-021 Data 8x8, filter 3x3, stride 1, pad 0, ch 2, num 1, win_ready=1, res_valid echoed 3 cycles later -> out 6x6, 72 windows, first window (0,0), last window (5,5), status 4, cout_cnt 1.
REQ-022 Data 5x5, filter 3x3, stride 2, pad 1 -> out 3x3, first win_row/win_col = -1/-1.
REQ-023 stride_h=0 -> status 8, no win_valid; a subsequent start with valid configuration completes normally.
REQ-024 res_valid held 0 -> exactly 15 windows accepted, then win_valid low; releasing res_valid resumes issue.
REQ-025 win_ready toggled randomly -> no window dropped or duplicated, and win_* stable while stalled.
REQ-026 abort issued mid-RUN -> IDLE next cycle, counters 0; start in the same cycle as abort ignored.
